// File: rtl/gpio_pkg.sv
// Register-map constants and address-width helper shared by the GPIO bank.
// GPIO_BOTH_EDGE_EN adds a second register page that holds the MODE register.
package gpio_pkg;

  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_IEN  = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  // MODE lives at offset 2 of page 1 when both-edge detection is built in
  localparam logic       PAGE_MODE = 1'b1;
  localparam logic [1:0] OFF_MODE  = 2'd2;

  function automatic int gpio_aw(input int nch);
`ifdef GPIO_BOTH_EDGE_EN
    return $clog2(nch) + 3;
`else
    return $clog2(nch) + 2;
`endif
  endfunction

endpackage

// File: rtl/gpio_chan.sv
// One W-bit GPIO channel: OUT/IEN/STAT registers, input synchroniser, edge detect.
// GPIO_BOTH_EDGE_EN adds a per-bit MODE register selecting rising or both edges.
module gpio_chan #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_out,
  input  logic         we_ien,
  input  logic         we_stat,
`ifdef GPIO_BOTH_EDGE_EN
  input  logic         we_mode,
  output logic [W-1:0] mode,
`endif
  input  logic [W-1:0] wd,
  input  logic [W-1:0] pins,
  output logic [W-1:0] out_data,
  output logic [W-1:0] in_data,
  output logic [W-1:0] ien,
  output logic [W-1:0] stat,
  output logic         irq
);

  logic [W-1:0] s1, s2, s3;
  logic [W-1:0] edges;
  logic [W-1:0] clr;

  always_comb begin
    edges = s2 & ~s3;
`ifdef GPIO_BOTH_EDGE_EN
    edges = edges | (mode & ~s2 & s3);
`endif
    clr = we_stat ? wd : '0;
  end

  // New edges are OR-ed in after the clear, so a same-cycle set beats W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      out_data <= '0;
      ien      <= '0;
      stat     <= '0;
`ifdef GPIO_BOTH_EDGE_EN
      mode     <= '0;
`endif
    end else begin
      s1   <= pins;
      s2   <= s1;
      s3   <= s2;
      stat <= (stat & ~clr) | edges;
      if (we_out) out_data <= wd;
      if (we_ien) ien <= wd;
`ifdef GPIO_BOTH_EDGE_EN
      if (we_mode) mode <= wd;
`endif
    end
  end

  assign in_data = s2;
  assign irq     = |(stat & ien);

endmodule

// File: rtl/gpio_bank.sv
// NCH-channel memory-mapped GPIO bank with a combined interrupt line.
// GPIO_BOTH_EDGE_EN enables the page-1 MODE register for both-edge detection.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int W   = 32,
  parameter int NCH = 4,
  parameter int AW  = gpio_aw(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    A,
  input  logic             WE,
  input  logic [W-1:0]     WD,
  output logic [W-1:0]     RD,
  input  logic [NCH*W-1:0] gpI,
  output logic [NCH*W-1:0] gpO,
  output logic             irq
);

  logic [AW-1:0]  ch_sel;
  logic [1:0]     off;
  logic           page;
  logic           hit;
  logic [W-1:0]   in_data [NCH];
  logic [W-1:0]   ien     [NCH];
  logic [W-1:0]   stat    [NCH];
  logic [NCH-1:0] irq_ch;
`ifdef GPIO_BOTH_EDGE_EN
  logic [W-1:0]   mode    [NCH];
`endif

  always_comb begin
    off = A[1:0];
`ifdef GPIO_BOTH_EDGE_EN
    page   = A[AW-1];
    ch_sel = (A & {1'b0, {(AW-1){1'b1}}}) >> 2;
`else
    page   = 1'b0;
    ch_sel = A >> 2;
`endif
    hit = ch_sel < AW'(NCH);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic sel;
    assign sel = WE && hit && (ch_sel == AW'(c));

    gpio_chan #(.W(W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .we_out   (sel && !page && off == OFF_OUT),
      .we_ien   (sel && !page && off == OFF_IEN),
      .we_stat  (sel && !page && off == OFF_STAT),
`ifdef GPIO_BOTH_EDGE_EN
      .we_mode  (sel && page == PAGE_MODE && off == OFF_MODE),
      .mode     (mode[c]),
`endif
      .wd       (WD),
      .pins     (gpI[c*W +: W]),
      .out_data (gpO[c*W +: W]),
      .in_data  (in_data[c]),
      .ien      (ien[c]),
      .stat     (stat[c]),
      .irq      (irq_ch[c])
    );
  end

  // Unmatched or out-of-range addresses fall through to the zero default
  always_comb begin
    RD = '0;
    for (int c = 0; c < NCH; c++) begin
      if (hit && ch_sel == AW'(c)) begin
        if (!page) begin
          case (off)
            OFF_OUT:  RD = gpO[c*W +: W];
            OFF_IN:   RD = in_data[c];
            OFF_IEN:  RD = ien[c];
            OFF_STAT: RD = stat[c];
          endcase
        end
`ifdef GPIO_BOTH_EDGE_EN
        else if (off == OFF_MODE) begin
          RD = mode[c];
        end
`endif
      end
    end
  end

  assign irq = |irq_ch;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (NCH=3, W=32) against a delay-line behavioural model.
// Exercises the MODE register as well when GPIO_BOTH_EDGE_EN is defined.
module tb_gpio_bank;

  localparam int W   = 32;
  localparam int NCH = 3;
  localparam int PW  = NCH * W;
`ifdef GPIO_BOTH_EDGE_EN
  localparam int AW  = 5;
`else
  localparam int AW  = 4;
`endif

  localparam logic [1:0] T_OUT  = 2'd0;
  localparam logic [1:0] T_IN   = 2'd1;
  localparam logic [1:0] T_IEN  = 2'd2;
  localparam logic [1:0] T_STAT = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] A   = '0;
  logic          WE  = 1'b0;
  logic [W-1:0]  WD  = '0;
  logic [W-1:0]  RD;
  logic [PW-1:0] gpI = '1;
  logic [PW-1:0] gpO;
  logic          irq;

  int total = 0;
  int bad   = 0;

  gpio_bank #(.W(W), .NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .WE  (WE),
    .WD  (WD),
    .RD  (RD),
    .gpI (gpI),
    .gpO (gpO),
    .irq (irq)
  );

  always #5 clk = ~clk;

  // Model state: register contents plus the last three input samples
  logic [W-1:0]  m_out  [NCH];
  logic [W-1:0]  m_ien  [NCH];
  logic [W-1:0]  m_stat [NCH];
  logic [W-1:0]  m_mode [NCH];
  logic [PW-1:0] samp   [3];
  bit            started = 0;

  task automatic checkOutput(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr(input int ch, input logic [1:0] off, input logic page = 1'b0);
    logic [1:0] chb;
    chb = ch[1:0];
    return AW'({page, chb, off});
  endfunction

  function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a);
    int ch;
    logic pg;
    ch = int'(a[3:2]);
`ifdef GPIO_BOTH_EDGE_EN
    pg = a[AW-1];
`else
    pg = 1'b0;
`endif
    if (ch >= NCH) return '0;
    if (pg) return (a[1:0] == 2'd2) ? m_mode[ch] : '0;
    case (a[1:0])
      2'd0:    return m_out[ch];
      2'd1:    return samp[1][ch*W +: W];
      2'd2:    return m_ien[ch];
      default: return m_stat[ch];
    endcase
  endfunction

  // An input value seen at edge k is IN after k+1 and reaches STAT at k+2
  always @(posedge clk) begin
    int ch;
    logic pg;
    logic [PW-1:0] rising, falling;
    logic [W-1:0] clr, flag;
    started = 1;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_out[c] = '0; m_ien[c] = '0; m_stat[c] = '0; m_mode[c] = '0;
      end
      for (int i = 0; i < 3; i++) samp[i] = '0;
    end else begin
      rising  = samp[1] & ~samp[2];
      falling = ~samp[1] & samp[2];
      ch = int'(A[3:2]);
`ifdef GPIO_BOTH_EDGE_EN
      pg = A[AW-1];
`else
      pg = 1'b0;
`endif
      for (int c = 0; c < NCH; c++) begin
        flag = rising[c*W +: W] | (m_mode[c] & falling[c*W +: W]);
        clr  = (WE && !pg && ch == c && A[1:0] == T_STAT) ? WD : '0;
        m_stat[c] = (m_stat[c] & ~clr) | flag;
        if (WE && !pg && ch == c && A[1:0] == T_OUT) m_out[c] = WD;
        if (WE && !pg && ch == c && A[1:0] == T_IEN) m_ien[c] = WD;
        if (WE && pg && ch == c && A[1:0] == 2'd2) m_mode[c] = WD;
      end
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = gpI;
    end
  end

  always @(negedge clk) begin
    logic [PW-1:0] exp_o;
    logic exp_irq;
    if (started) begin
      exp_irq = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        exp_o[c*W +: W] = m_out[c];
        exp_irq = exp_irq | (|(m_stat[c] & m_ien[c]));
      end
      checkOutput("model_gpo", gpO, exp_o);
      checkOutput("model_irq", PW'(irq), PW'(exp_irq));
      checkOutput("model_rd", PW'(RD), PW'(model_rd(A)));
    end
  end

  task automatic applyStimulus(input logic r, input logic [AW-1:0] a, input logic we,
                               input logic [W-1:0] wd, input logic [PW-1:0] gpi);
    @(posedge clk);
    #2;
    rst = r; A = a; WE = we; WD = wd; gpI = gpi;
  endtask

  task automatic expectRd(input string name, input logic [W-1:0] exp);
    @(negedge clk);
    checkOutput(name, PW'(RD), PW'(exp));
  endtask

  initial begin
    logic [PW-1:0] ones, b32;
    logic [1:0] o;
    ones = '1;
    b32  = PW'(1) << 32;

    // Reset with inputs high: every OUT/IEN/STAT address reads 0
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 3; k++) begin
        o = (k == 0) ? T_OUT : 2'(k + 1);
        applyStimulus(1'b1, addr(c, o), 1'b0, '0, ones);
        expectRd("rst_rd", '0);
      end
    end
    checkOutput("rst_gpo", gpO, '0);
    checkOutput("rst_irq", PW'(irq), '0);

    // Inputs held high through reset yield one edge two cycles after release
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, ones);
    expectRd("stat_pre", '0);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, ones);
    expectRd("stat_e0", '0);
    applyStimulus(1'b0, addr(0, T_IN), 1'b0, '0, ones);
    expectRd("in_e1", 32'hFFFF_FFFF);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, ones);
    expectRd("stat_e2", 32'hFFFF_FFFF);

    for (int c = 0; c < NCH; c++) applyStimulus(1'b0, addr(c, T_STAT), 1'b1, '1, ones);
    applyStimulus(1'b0, addr(2, T_STAT), 1'b0, '0, '0);
    expectRd("stat_clr", '0);

    // Output register write and readback
    applyStimulus(1'b0, addr(2, T_OUT), 1'b1, 32'hA5A5_0F0F, '0);
    applyStimulus(1'b0, addr(2, T_OUT), 1'b0, '0, '0);
    expectRd("out_rb", 32'hA5A5_0F0F);
    checkOutput("out_gpo", gpO, {32'hA5A5_0F0F, 64'h0});

    // Edge/irq latency on channel 1 bit 0
    applyStimulus(1'b0, addr(1, T_IEN), 1'b1, 32'h1, '0);
    applyStimulus(1'b0, addr(1, T_IN), 1'b0, '0, b32);
    expectRd("in_before", '0);
    applyStimulus(1'b0, addr(1, T_IN), 1'b0, '0, b32);
    expectRd("in_k", '0);
    applyStimulus(1'b0, addr(1, T_IN), 1'b0, '0, b32);
    expectRd("in_k1", 32'h1);
    checkOutput("irq_k1", PW'(irq), '0);
    applyStimulus(1'b0, addr(1, T_STAT), 1'b0, '0, '0);
    expectRd("stat_k2", 32'h1);
    checkOutput("irq_k2", PW'(irq), PW'(1));
    repeat (3) applyStimulus(1'b0, addr(1, T_STAT), 1'b0, '0, '0);
    expectRd("stat_sticky", 32'h1);
    applyStimulus(1'b0, addr(1, T_STAT), 1'b1, 32'h1, '0);
    applyStimulus(1'b0, addr(1, T_STAT), 1'b0, '0, '0);
    expectRd("stat_w1c", '0);
    checkOutput("irq_clr", PW'(irq), '0);

    // W1C colliding with a new rising edge on channel 0 bit 0
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, PW'(3));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, PW'(1));
    expectRd("stat_two", 32'h3);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, PW'(1));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b1, 32'h1, PW'(1));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, PW'(1));
    expectRd("w1c_collide", 32'h3);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b1, 32'h3, PW'(1));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, PW'(1));
    expectRd("w1c_all", '0);
    checkOutput("irq_w1c", PW'(irq), '0);

    // Channel 3 does not exist when NCH=3
    applyStimulus(1'b0, addr(3, T_OUT), 1'b1, 32'hDEAD_BEEF, PW'(1));
    applyStimulus(1'b0, addr(3, T_OUT), 1'b0, '0, PW'(1));
    expectRd("oor_rd", '0);
    checkOutput("oor_gpo", gpO, {32'hA5A5_0F0F, 64'h0});
    applyStimulus(1'b0, addr(0, T_IN), 1'b1, 32'h0, PW'(1));
    applyStimulus(1'b0, addr(0, T_IN), 1'b0, '0, PW'(1));
    expectRd("in_ro", 32'h1);

`ifdef GPIO_BOTH_EDGE_EN
    // Falling edge flagged only while MODE is set
    applyStimulus(1'b0, addr(0, 2'd2, 1'b1), 1'b1, 32'h1, PW'(1));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b1, '1, PW'(1));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    expectRd("fall_f0", '0);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    expectRd("fall_f2", 32'h1);
    applyStimulus(1'b0, addr(0, 2'd2, 1'b1), 1'b1, 32'h0, PW'(1));
    applyStimulus(1'b0, addr(0, 2'd2, 1'b1), 1'b0, '0, PW'(1));
    expectRd("mode_rb", '0);
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, PW'(1));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b1, '1, PW'(1));
    applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    repeat (3) applyStimulus(1'b0, addr(0, T_STAT), 1'b0, '0, '0);
    expectRd("fall_nomode", '0);
`endif

    // Reset mid-operation clears the output registers
    applyStimulus(1'b1, addr(2, T_OUT), 1'b0, '0, '0);
    applyStimulus(1'b0, addr(2, T_OUT), 1'b0, '0, '0);
    expectRd("rst_mid_rd", '0);
    checkOutput("rst_mid_gpo", gpO, '0);

    repeat (2) applyStimulus(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
